// File: rtl/bp_cce_dir_op_sequencer.sv
// bp_cce_dir_op_sequencer
// Round-robin arbiter and sequencer that shares the CCE coherence directory
// between several requesters. One directory op is in flight at a time. Read
// ops wait for a completion pulse. A tagged response is returned to the
// winning requester.
// Optional feature macro: BP_CCE_DIR_SEQ_TIMEOUT_EN
//   When defined, a watchdog bounds the WAIT state to timeout_p cycles and
//   reports resp_err_o = 1 on expiry.
//   When undefined, WAIT is unbounded and resp_err_o is tied to 0.
module bp_cce_dir_op_sequencer #(
  parameter int num_req_p   = 2,
  parameter int pkt_width_p = 64,
  parameter int timeout_p   = 64,
  localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p-1:0]             req_w_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic [pkt_width_p-1:0]           dir_pkt_o,
  output logic                             dir_r_v_o,
  output logic                             dir_w_v_o,
  input  logic                             dir_busy_i,
  input  logic                             dir_sharers_v_i,
  input  logic                             dir_addr_v_i,
  output logic                             resp_v_o,
  output logic [lg_num_req_lp-1:0]         resp_id_o,
  output logic                             resp_w_o,
  output logic                             resp_err_o,
  input  logic                             resp_yumi_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [lg_num_req_lp-1:0] rr_q, rr_d;
  logic [pkt_width_p-1:0]   pkt_q, pkt_d;
  logic [lg_num_req_lp-1:0] id_q, id_d;
  logic                     w_q, w_d;

  logic                     grant_found;
  logic [lg_num_req_lp-1:0] grant_id;
  logic                     rd_done;

  // Either completion pulse (or both together) ends a read.
  assign rd_done = dir_sharers_v_i | dir_addr_v_i;

`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_p + 1);
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [cnt_width_lp-1:0] cnt_inc;
  logic                    err_q, err_d;

  assign cnt_inc = cnt_q + 1'b1;

  // Watchdog: held at zero outside WAIT, so it is clear on WAIT entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) begin
      cnt_d = cnt_inc;
    end
  end
`endif

  // Pick the first valid requester scanning upward from the rr pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % num_req_p;
      if (!grant_found && req_v_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = lg_num_req_lp'(idx);
      end
    end
  end

  // Next-state and output decode for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    pkt_d       = pkt_q;
    id_d        = id_q;
    w_d         = w_q;
    req_ready_o = '0;
    dir_r_v_o   = 1'b0;
    dir_w_v_o   = 1'b0;
    resp_v_o    = 1'b0;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_found && !dir_busy_i) begin
          req_ready_o[grant_id] = 1'b1;
          pkt_d   = req_pkt_i[grant_id*pkt_width_p +: pkt_width_p];
          id_d    = grant_id;
          w_d     = req_w_i[grant_id];
          rr_d    = (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + 1'b1;
          state_d = ISSUE;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (!dir_busy_i) begin
          if (w_q) begin
            dir_w_v_o = 1'b1;
            state_d   = RESP;
          end else begin
            dir_r_v_o = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (rd_done) begin
          state_d = RESP;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_inc == cnt_width_lp'(timeout_p)) begin
          state_d = RESP;
          err_d   = 1'b1;
`endif
        end
      end
      RESP: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-op registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      pkt_q   <= '0;
      id_q    <= '0;
      w_q     <= 1'b0;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      id_q    <= id_d;
      w_q     <= w_d;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign dir_pkt_o = pkt_q;
  assign resp_id_o = resp_v_o ? id_q : '0;
  assign resp_w_o  = resp_v_o & w_q;
`ifdef BP_CCE_DIR_SEQ_TIMEOUT_EN
  assign resp_err_o = resp_v_o & err_q;
`else
  assign resp_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  // Requesters that were valid but not granted last cycle.
  logic [num_req_p-1:0] req_pend_q;

  // Protocol checks on the requester and directory interfaces.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_pend_q <= '0;
    end else begin
      req_pend_q <= req_v_i & ~req_ready_o;
      assert (num_req_p >= 1 && timeout_p >= 1);
      assert (!(dir_r_v_o && dir_w_v_o));
      assert ($onehot0(req_ready_o));
      assert ((req_pend_q & ~req_v_i) == '0);
      assert ((state_q == WAIT) || !rd_done);
    end
  end
`endif

endmodule
